// File: rtl/aes_pkg.sv
// Shared AES constants, types and GF(2^8) helpers used by the encrypt and decrypt engines.
package aes_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int AES_ROUNDS = 10;

    typedef logic [7:0]            byte_t;
    typedef logic [31:0]           word_t;
    typedef logic [BLOCK_BITS-1:0] block_t;

    typedef enum logic [1:0] {IDLE, ROUND, LAST} dec_state_t;

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; only 9, 11, 13 and 14 are needed here.
    function automatic byte_t gf_mul(input byte_t b, input logic [3:0] k);
        byte_t p = 8'h00;
        byte_t x = b;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic word_t inv_mix_col(input word_t col);
        byte_t a0 = col[31:24];
        byte_t a1 = col[23:16];
        byte_t a2 = col[15:8];
        byte_t a3 = col[7:0];
        return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
                gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
                gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
                gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
    endfunction

endpackage

// File: rtl/decrypt_inv_round.sv
// One combinational inverse AES round; the final round skips InvMixColumns.
module invRound
    import aes_pkg::*;
(
    input  block_t input_data,
    input  block_t keyword,
    input  logic   last,
    output block_t output_data
);

    block_t keyed;
    block_t mixed;

    // Byte i sits at row i%4, column i/4; InvShiftRows rotates row r right by r.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = ((C - R + 4) % 4) * 4 + R;
        assign keyed[127-8*i -: 8] = INV_SBOX[input_data[127-8*SRC -: 8]] ^ keyword[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
        assign mixed[127-32*c -: 32] = inv_mix_col(keyed[127-32*c -: 32]);
    end

    assign output_data = last ? keyed : mixed;

endmodule

// File: rtl/decrypt.sv
// Iterative AES-128 decryption engine: one inverse round per HCLK, 11-cycle latency.
module decrypt
    import aes_pkg::*;
(
    input  logic   HCLK,
    input  logic   n_rst,
    input  logic   ena,
    input  logic   start,
    input  block_t inData,
    input  block_t keyword,
    input  block_t subkey0,
    input  block_t subkey1,
    input  block_t subkey2,
    input  block_t subkey3,
    input  block_t subkey4,
    input  block_t subkey5,
    input  block_t subkey6,
    input  block_t subkey7,
    input  block_t subkey8,
    input  block_t subkey9,
    output logic   busy,
    output logic   done,
    output block_t result
);

    dec_state_t fsm;
    logic [3:0] cnt;
    block_t     st;
    block_t     round_key;
    block_t     round_out;

    // NOTE: round_key gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        round_key = subkey0;
        case (cnt)
            4'd1:    round_key = subkey1;
            4'd2:    round_key = subkey2;
            4'd3:    round_key = subkey3;
            4'd4:    round_key = subkey4;
            4'd5:    round_key = subkey5;
            4'd6:    round_key = subkey6;
            4'd7:    round_key = subkey7;
            4'd8:    round_key = subkey8;
            default: round_key = subkey0;
        endcase
        if (fsm == LAST) round_key = keyword;
    end

    invRound u_inv_round (
        .input_data (st),
        .keyword    (round_key),
        .last       (fsm == LAST),
        .output_data(round_out)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK or negedge n_rst) begin
        if (!n_rst) begin
            fsm    <= IDLE;
            cnt    <= 4'd0;
            st     <= '0;
            done   <= 1'b0;
            result <= '0;
        end else if (!ena) begin
            // Abort keeps the last plaintext in result.
            fsm  <= IDLE;
            cnt  <= 4'd0;
            st   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                IDLE: if (start) begin
                    st  <= inData ^ subkey9;
                    cnt <= 4'(AES_ROUNDS - 2);
                    fsm <= ROUND;
                end
                ROUND: begin
                    st <= round_out;
                    if (cnt == 4'd0) fsm <= LAST;
                    else             cnt <= cnt - 4'd1;
                end
                LAST: begin
                    result <= round_out;
                    done   <= 1'b1;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    assign busy = (fsm != IDLE);

endmodule

// File: tb/tb_decrypt.sv
// Self-checking bench for decrypt: FIPS-197 vectors, abort/reset cases and random round trips.
module tb_decrypt;

    logic         HCLK = 1'b0;
    logic         n_rst, ena, start;
    logic [127:0] inData, keyword;
    logic [127:0] subkey0, subkey1, subkey2, subkey3, subkey4;
    logic [127:0] subkey5, subkey6, subkey7, subkey8, subkey9;
    logic         busy, done;
    logic [127:0] result;

    always #5 HCLK = ~HCLK;

    decrypt dut (
        .HCLK   (HCLK),
        .n_rst  (n_rst),
        .ena    (ena),
        .start  (start),
        .inData (inData),
        .keyword(keyword),
        .subkey0(subkey0),
        .subkey1(subkey1),
        .subkey2(subkey2),
        .subkey3(subkey3),
        .subkey4(subkey4),
        .subkey5(subkey5),
        .subkey6(subkey6),
        .subkey7(subkey7),
        .subkey8(subkey8),
        .subkey9(subkey9),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model: forward AES-128 built from GF(2^8) arithmetic.
    logic [7:0]   sb [256];
    logic [127:0] rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [7:0] gb(input logic [127:0] s, input int r, input int c);
        return s[127-8*(4*c+r) -: 8];
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s = pt ^ rk[0];
        logic [127:0] t;
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = sb[s[127-8*i -: 8]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[127-8*(4*c+r) -: 8] = gb(s, r, (c + r) % 4);
            s = t;
            if (rnd < 10)
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[127-8*(4*c+r) -: 8] = gmul(gb(s, r, c), 8'h02) ^ gmul(gb(s, (r+1)%4, c), 8'h03)
                                              ^ gb(s, (r+2)%4, c) ^ gb(s, (r+3)%4, c);
            s = t ^ rk[rnd];
        end
        return s;
    endfunction

    task automatic load_keys(input logic [127:0] key);
        expand_key(key);
        keyword = rk[0];
        subkey0 = rk[1]; subkey1 = rk[2]; subkey2 = rk[3]; subkey3 = rk[4]; subkey4 = rk[5];
        subkey5 = rk[6]; subkey6 = rk[7]; subkey7 = rk[8]; subkey8 = rk[9]; subkey9 = rk[10];
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so the next call runs back-to-back.
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                             input int pulse_a, input int pulse_b);
        inData = ct;
        start  = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge HCLK);
            if (k == 1) inData = {$urandom, $urandom, $urandom, $urandom};
            start = (k == pulse_a || k == pulse_b);
            if (k == 11) start = 1'b0;
            check({tag, "_busy"}, 128'(busy), 128'(k < 11));
            check({tag, "_done"}, 128'(done), 128'(k == 11));
        end
        check({tag, "_result"}, result, exp);
    endtask

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] key, pt;
        build_sbox();
        n_rst = 1'b0; ena = 1'b1; start = 1'b0; inData = '0;
        load_keys(KEY_C1);
        repeat (2) @(negedge HCLK);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        check("reset_result", result, '0);
        n_rst = 1'b1;
        @(negedge HCLK);

        run_block("c1", CT_C1, PT_C1, 0, 0);

        load_keys(KEY_B);
        inData = CT_B;
        start  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge HCLK);
            start = 1'b0;
        end
        ena = 1'b0;
        @(negedge HCLK);
        check("abort_busy", 128'(busy), 128'(0));
        for (int k = 0; k < 12; k++) begin
            @(negedge HCLK);
            check("abort_done", 128'(done), 128'(0));
        end
        check("abort_result_held", result, PT_C1);
        ena = 1'b1;
        @(negedge HCLK);

        run_block("b_restart", CT_B, PT_B, 0, 0);

        load_keys(KEY_C1);
        run_block("c1_pulses", CT_C1, PT_C1, 3, 7);
        for (int k = 0; k < 12; k++) begin
            @(negedge HCLK);
            check("pulses_no_extra_done", 128'(done), 128'(0));
            check("pulses_no_extra_busy", 128'(busy), 128'(0));
        end

        for (int i = 0; i < 100; i++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            load_keys(key);
            run_block("roundtrip", encrypt(pt), pt, 0, 0);
        end

        load_keys(KEY_B);
        inData = CT_B;
        start  = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        repeat (4) @(negedge HCLK);
        #2 n_rst = 1'b0;
        #1;
        check("async_rst_busy", 128'(busy), 128'(0));
        check("async_rst_done", 128'(done), 128'(0));
        check("async_rst_result", result, '0);
        @(negedge HCLK);
        n_rst = 1'b1;
        repeat (12) begin
            @(negedge HCLK);
            check("post_rst_done", 128'(done), 128'(0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
